// File: rtl/bp_be_fetch_instr_queue_if.sv
// Handshake bundle between the FE command side, the BE decoder and the
// instruction queue.
//   slave  : the queue's view (takes enqueue and issue controls, drives ready and the issue entry)
//   master : the producer/consumer view (drives the controls, receives the issue entry)
interface bp_be_fetch_instr_queue_if #(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int exc_width_p   = 2
) ();
    // enqueue side
    logic                     v_i;
    logic                     ready_o;
    logic [vaddr_width_p-1:0] pc_i;
    logic [instr_width_p-1:0] instr_i;
    logic                     exc_not_instr_i;
    logic [exc_width_p-1:0]   exc_i;
    // issue side
    logic                     v_o;
    logic [vaddr_width_p-1:0] pc_o;
    logic [instr_width_p-1:0] instr_o;
    logic                     exc_not_instr_o;
    logic [exc_width_p-1:0]   exc_o;
    logic                     yumi_i;
    // commit / redirect controls
    logic                     cmt_i;
    logic                     roll_i;
    logic                     clr_i;

    modport slave (
        input  v_i, pc_i, instr_i, exc_not_instr_i, exc_i, yumi_i, cmt_i, roll_i, clr_i,
        output ready_o, v_o, pc_o, instr_o, exc_not_instr_o, exc_o
    );

    modport master (
        output v_i, pc_i, instr_i, exc_not_instr_i, exc_i, yumi_i, cmt_i, roll_i, clr_i,
        input  ready_o, v_o, pc_o, instr_o, exc_not_instr_o, exc_o
    );
endinterface

// File: rtl/bp_be_fetch_instr_queue.sv
// Circular instruction buffer between the FE command interface and the BE
// decoder. Entries {pc, instr, exception} stay resident until committed; the
// oldest un-issued entry is presented to the decoder. roll_i rewinds issue to
// the oldest uncommitted entry, clr_i empties the queue.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   q_if       enqueue / issue / commit / redirect bundle (slave view)
module bp_be_fetch_instr_queue #(
    parameter int depth_p       = 8,
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter int exc_width_p   = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    bp_be_fetch_instr_queue_if.slave   q_if
);
    localparam int ptr_width_lp = $clog2(depth_p) + 1;
    localparam int idx_width_lp = ptr_width_lp - 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t cptr_q, cptr_d;

    logic [vaddr_width_p-1:0] pc_mem_q    [depth_p];
    logic [instr_width_p-1:0] instr_mem_q [depth_p];
    logic                     excf_mem_q  [depth_p];
    logic [exc_width_p-1:0]   exc_mem_q   [depth_p];

    logic full;
    logic enq;
    logic [idx_width_lp-1:0] widx, ridx;

    assign widx = wptr_q[idx_width_lp-1:0];
    assign ridx = rptr_q[idx_width_lp-1:0];

    // Full: same slot index, opposite wrap bit. Based on registered state only,
    // so a commit in this cycle cannot raise ready_o until the next one.
    assign full = (wptr_q[idx_width_lp-1:0] == cptr_q[idx_width_lp-1:0])
               && (wptr_q[ptr_width_lp-1] != cptr_q[ptr_width_lp-1]);

    assign q_if.ready_o = ~full;
    // clr_i drops any enqueue in the same cycle.
    assign enq = q_if.v_i & ~full & ~q_if.clr_i;

    // No bypass: issue sees only what is already in storage.
    assign q_if.v_o             = (rptr_q != wptr_q);
    assign q_if.pc_o            = pc_mem_q[ridx];
    assign q_if.instr_o         = instr_mem_q[ridx];
    assign q_if.exc_not_instr_o = excf_mem_q[ridx];
    assign q_if.exc_o           = exc_mem_q[ridx];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cptr_d = cptr_q;
        if (q_if.clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cptr_d = '0;
        end else begin
            if (enq)        wptr_d = wptr_q + ptr_t'(1);
            if (q_if.cmt_i) cptr_d = cptr_q + ptr_t'(1);
            // Roll rewinds to the oldest entry still uncommitted after this
            // cycle's commit; yumi_i is ignored while rolling.
            if (q_if.roll_i)      rptr_d = cptr_d;
            else if (q_if.yumi_i) rptr_d = rptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cptr_q <= cptr_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < depth_p; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
                excf_mem_q[i]  <= 1'b0;
                exc_mem_q[i]   <= '0;
            end
        end else if (enq) begin
            pc_mem_q[widx]    <= q_if.pc_i;
            instr_mem_q[widx] <= q_if.instr_i;
            excf_mem_q[widx]  <= q_if.exc_not_instr_i;
            exc_mem_q[widx]   <= q_if.exc_i;
        end
    end

    // Protocol misuse is flagged, not corrected.
    a_yumi_needs_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        q_if.yumi_i |-> q_if.v_o);
    a_cmt_needs_issued : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        q_if.cmt_i |-> (cptr_q != rptr_q));
endmodule

// File: tb/tb_bp_be_fetch_instr_queue.sv
module tb_bp_be_fetch_instr_queue;
    localparam int VA = 39;
    localparam int IW = 32;
    localparam int EW = 2;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    bp_be_fetch_instr_queue_if #(.vaddr_width_p(VA), .instr_width_p(IW), .exc_width_p(EW)) q_if ();

    bp_be_fetch_instr_queue #(
        .depth_p(8), .vaddr_width_p(VA), .instr_width_p(IW), .exc_width_p(EW)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .q_if      (q_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        q_if.v_i = 1'b0; q_if.yumi_i = 1'b0; q_if.cmt_i = 1'b0;
        q_if.roll_i = 1'b0; q_if.clr_i = 1'b0;
        q_if.exc_not_instr_i = 1'b0; q_if.exc_i = '0;
    endtask

    task automatic enq(input logic [VA-1:0] pc, input logic [IW-1:0] ins);
        idle();
        q_if.v_i = 1'b1; q_if.pc_i = pc; q_if.instr_i = ins;
        step();
        idle();
    endtask

    task automatic pulse_clr();
        idle();
        q_if.clr_i = 1'b1;
        step();
        idle();
    endtask

    initial begin
        idle();
        q_if.pc_i = '0; q_if.instr_i = '0;
        #12;
        reset_n_i = 1'b1;
        #1;

        // 1: reset state, then single entry with one-cycle latency
        chk("rst_ready", 64'(q_if.ready_o), 64'd1);
        chk("rst_v", 64'(q_if.v_o), 64'd0);
        chk("rst_pc", 64'(q_if.pc_o), 64'd0);
        chk("rst_instr", 64'(q_if.instr_o), 64'd0);
        @(negedge clk_i);
        q_if.v_i = 1'b1; q_if.pc_i = 39'h0080000000; q_if.instr_i = 32'h00000013;
        #1 chk("t1_no_bypass", 64'(q_if.v_o), 64'd0);
        step();
        idle();
        chk("t1_v", 64'(q_if.v_o), 64'd1);
        chk("t1_pc", 64'(q_if.pc_o), 64'h80000000);
        chk("t1_instr", 64'(q_if.instr_o), 64'h13);
        chk("t1_excf", 64'(q_if.exc_not_instr_o), 64'd0);
        pulse_clr();

        // 2: fill, drain issue, commit frees a slot
        for (int i = 0; i < 8; i++) begin
            chk("t2_ready_fill", 64'(q_if.ready_o), 64'd1);
            enq(39'h1000 + 39'(i * 4), 32'h100 + 32'(i));
        end
        chk("t2_full", 64'(q_if.ready_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_issue_pc", 64'(q_if.pc_o), 64'h1000 + 64'(i * 4));
            chk("t2_issue_instr", 64'(q_if.instr_o), 64'h100 + 64'(i));
            q_if.yumi_i = 1'b1;
            step();
            idle();
        end
        chk("t2_drained_v", 64'(q_if.v_o), 64'd0);
        chk("t2_still_full", 64'(q_if.ready_o), 64'd0);
        q_if.cmt_i = 1'b1;
        #1 chk("t2_no_same_cycle_ready", 64'(q_if.ready_o), 64'd0);
        step();
        idle();
        chk("t2_ready_after_cmt", 64'(q_if.ready_o), 64'd1);
        pulse_clr();

        // 3: roll after a separate commit
        enq(39'h2000, 32'hA); enq(39'h2004, 32'hB); enq(39'h2008, 32'hC);
        q_if.yumi_i = 1'b1; step(); step(); idle();
        chk("t3_at_C", 64'(q_if.pc_o), 64'h2008);
        q_if.cmt_i = 1'b1; step(); idle();
        q_if.roll_i = 1'b1; step(); idle();
        chk("t3_roll_v", 64'(q_if.v_o), 64'd1);
        chk("t3_roll_pc", 64'(q_if.pc_o), 64'h2004);
        q_if.yumi_i = 1'b1; step(); idle();
        chk("t3_next_pc", 64'(q_if.pc_o), 64'h2008);
        pulse_clr();

        // 4: roll with commit in the same cycle; yumi ignored while rolling
        enq(39'h2100, 32'hA); enq(39'h2104, 32'hB); enq(39'h2108, 32'hC);
        q_if.yumi_i = 1'b1; step(); step(); idle();
        q_if.roll_i = 1'b1; q_if.cmt_i = 1'b1; q_if.yumi_i = 1'b1;
        step(); idle();
        chk("t4_roll_cmt_pc", 64'(q_if.pc_o), 64'h2104);
        chk("t4_roll_cmt_v", 64'(q_if.v_o), 64'd1);
        pulse_clr();

        // 5: clr with simultaneous enqueue drops it
        enq(39'h3000, 32'h1); enq(39'h3004, 32'h2); enq(39'h3008, 32'h3);
        q_if.clr_i = 1'b1; q_if.v_i = 1'b1; q_if.pc_i = 39'hDEAD0;
        step(); idle();
        chk("t5_v", 64'(q_if.v_o), 64'd0);
        chk("t5_ready", 64'(q_if.ready_o), 64'd1);
        step();
        chk("t5_dropped", 64'(q_if.v_o), 64'd0);
        enq(39'h3100, 32'h77);
        chk("t5_new_pc", 64'(q_if.pc_o), 64'h3100);
        pulse_clr();

        // 6: streaming with simultaneous enq/yumi/cmt, wrapping slots
        for (int k = 0; k < 22; k++) begin
            idle();
            if (k < 20) begin
                q_if.v_i = 1'b1; q_if.pc_i = 39'h4000 + 39'(k * 4); q_if.instr_i = 32'(k);
            end
            if (k >= 1 && k <= 20) begin
                q_if.yumi_i = 1'b1;
                chk("t6_stream_pc", 64'(q_if.pc_o), 64'h4000 + 64'((k - 1) * 4));
            end
            if (k >= 2) q_if.cmt_i = 1'b1;
            step();
        end
        idle();
        chk("t6_empty", 64'(q_if.v_o), 64'd0);
        idle();
        q_if.v_i = 1'b1; q_if.pc_i = 39'h5000; q_if.instr_i = '0;
        q_if.exc_not_instr_i = 1'b1; q_if.exc_i = 2'd2;
        step(); idle();
        chk("t6_exc_v", 64'(q_if.v_o), 64'd1);
        chk("t6_excf", 64'(q_if.exc_not_instr_o), 64'd1);
        chk("t6_exc", 64'(q_if.exc_o), 64'd2);
        chk("t6_exc_pc", 64'(q_if.pc_o), 64'h5000);

        // asynchronous reset mid-operation
        enq(39'h6000, 32'h9);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_v", 64'(q_if.v_o), 64'd0);
        chk("arst_ready", 64'(q_if.ready_o), 64'd1);
        chk("arst_pc", 64'(q_if.pc_o), 64'd0);
        #4 reset_n_i = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
